// File: rtl/sat_engine_pkg.sv
// sat_engine_pkg: shared widths, backtrack controller state encoding and findflag codes
package sat_engine_pkg;
  localparam int WIDTH_LVL        = 16;
  localparam int WIDTH_BIN        = 10;
  localparam int WIDTH_LVL_STATES = WIDTH_BIN + 1;
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETTLE = 3'd1,
    ENCODE = 3'd2,
    APPLY  = 3'd3,
    RESULT = 3'd4
  } bkt_ctrl_state_t;
  localparam logic [1:0] FF_NONE = 2'd0;
  localparam logic [1:0] FF_HIT  = 2'd1;
  localparam logic [1:0] FF_DONE = 2'd2;
endpackage

// File: rtl/prio_enc_hi.sv
// prio_enc_hi: combinational highest-set-bit index with any/multiple-hit flags
module prio_enc_hi #(
  parameter int N = 32,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] vec,
  output logic [W-1:0] idx,
  output logic         any,
  output logic         multi
);
  always_comb begin
    idx = '0;
    for (int i = 0; i < N; i++) idx = vec[i] ? W'(i) : idx;
  end
  assign any   = |vec;
  assign multi = (vec & (vec - N'(1))) != '0;
endmodule

// File: rtl/bkt_lvl_ctrl.sv
// bkt_lvl_ctrl: drives max_lvl into the lvl_state_cell chain, encodes findindex, commits backtrack
module bkt_lvl_ctrl
  import sat_engine_pkg::*;
#(
  parameter int NUM_LVLS         = 32,
  parameter int WIDTH_LVL        = sat_engine_pkg::WIDTH_LVL,
  parameter int WIDTH_BIN        = sat_engine_pkg::WIDTH_BIN,
  parameter int WIDTH_LVL_STATES = sat_engine_pkg::WIDTH_LVL_STATES,
  parameter int WIDTH_IDX        = $clog2(NUM_LVLS)
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 start_i,
  input  logic [WIDTH_LVL-1:0]                 max_lvl_i,
  output logic                                 busy_o,
  output logic [WIDTH_LVL-1:0]                 max_lvl_o,
  output logic [1:0]                           findflag_o,
  input  logic [NUM_LVLS-1:0]                  findindex_i,
  input  logic [NUM_LVLS*WIDTH_LVL_STATES-1:0] lvl_states_i,
  output logic                                 apply_bkt_o,
  output logic                                 result_valid_o,
  input  logic                                 result_ready_i,
  output logic [WIDTH_LVL-1:0]                 bkt_lvl_o,
  output logic [WIDTH_BIN-1:0]                 bkt_bin_o,
  output logic                                 unsat_o,
  output logic                                 multi_hit_o
);
  bkt_ctrl_state_t      state, nxt;
  logic [WIDTH_IDX-1:0] enc_idx, idx_q;
  logic                 enc_any, enc_multi, found_q;
  logic [WIDTH_BIN-1:0] sel_bin;

  prio_enc_hi #(.N(NUM_LVLS), .W(WIDTH_IDX)) u_enc (
    .vec  (findindex_i),
    .idx  (enc_idx),
    .any  (enc_any),
    .multi(enc_multi)
  );

  // dcd_bin sits above the has_bkt bit in each level's state word
  assign sel_bin = lvl_states_i[int'(idx_q)*WIDTH_LVL_STATES+1 +: WIDTH_BIN];

  always_ff @(posedge clk) state <= rst ? IDLE : nxt;

  always_comb begin
    nxt = state == IDLE   ? (start_i ? SETTLE : IDLE) :
          state == SETTLE ? ENCODE :
          state == ENCODE ? APPLY :
          state == APPLY  ? RESULT :
          (state == RESULT && !result_ready_i) ? RESULT : IDLE;
  end

  assign busy_o         = state != IDLE;
  assign apply_bkt_o    = state == APPLY && found_q;
  assign result_valid_o = state == RESULT;
  assign findflag_o     = FF_NONE;

  always_ff @(posedge clk) begin
    if (rst) begin
      max_lvl_o   <= '0;
      idx_q       <= '0;
      found_q     <= 1'b0;
      bkt_lvl_o   <= '0;
      bkt_bin_o   <= '0;
      unsat_o     <= 1'b0;
      multi_hit_o <= 1'b0;
    end else begin
      if (state == IDLE && start_i) max_lvl_o <= max_lvl_i;
      if (state == ENCODE) begin
        idx_q       <= enc_idx;
        found_q     <= enc_any;
        multi_hit_o <= multi_hit_o | enc_multi;
      end
      // bin is captured before the cells act on this cycle's apply pulse
      if (state == APPLY) begin
        bkt_lvl_o <= found_q ? WIDTH_LVL'(idx_q) : '0;
        bkt_bin_o <= found_q ? sel_bin : '0;
        unsat_o   <= !found_q;
      end
    end
  end
endmodule

// File: tb/tb_bkt_lvl_ctrl.sv
// tb_bkt_lvl_ctrl: table-driven scoreboard bench for the backtrack level controller
module tb_bkt_lvl_ctrl;
  localparam int NL = 32;
  localparam int WS = 11;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start_i = 1'b0;
  logic [15:0]      max_lvl_i = '0;
  logic             busy_o;
  logic [15:0]      max_lvl_o;
  logic [1:0]       findflag_o;
  logic [NL-1:0]    findindex_i = '0;
  logic [NL*WS-1:0] lvl_states_i = '0;
  logic             apply_bkt_o;
  logic             result_valid_o;
  logic             result_ready_i = 1'b0;
  logic [15:0]      bkt_lvl_o;
  logic [9:0]       bkt_bin_o;
  logic             unsat_o;
  logic             multi_hit_o;

  int cmp_cnt = 0;
  int err_cnt = 0;

  typedef struct {
    logic [31:0] fi;
    logic [15:0] maxl;
    int          lvl;
    logic [9:0]  bin;
    bit          unsat;
    bit          multi;
    int          hold;
  } vec_t;

  vec_t tbl[8];
  vec_t sb[$];

  bkt_lvl_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .start_i       (start_i),
    .max_lvl_i     (max_lvl_i),
    .busy_o        (busy_o),
    .max_lvl_o     (max_lvl_o),
    .findflag_o    (findflag_o),
    .findindex_i   (findindex_i),
    .lvl_states_i  (lvl_states_i),
    .apply_bkt_o   (apply_bkt_o),
    .result_valid_o(result_valid_o),
    .result_ready_i(result_ready_i),
    .bkt_lvl_o     (bkt_lvl_o),
    .bkt_bin_o     (bkt_bin_o),
    .unsat_o       (unsat_o),
    .multi_hit_o   (multi_hit_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    cmp_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic load_states(input vec_t v);
    for (int i = 0; i < NL; i++) lvl_states_i[i*WS +: WS] = {10'(i*19 + 3), i[0]};
    if (!v.unsat) lvl_states_i[v.lvl*WS+1 +: 10] = v.bin;
  endtask

  // Call at a negedge with the DUT idle; returns at the negedge where it is idle again.
  task automatic run(input vec_t v);
    vec_t e;
    findindex_i = v.fi;
    max_lvl_i   = v.maxl;
    load_states(v);
    result_ready_i = 1'b0;
    start_i = 1'b1;
    sb.push_back(v);
    for (int n = 1; n <= 5 + v.hold; n++) begin
      @(negedge clk);
      max_lvl_i      = ~v.maxl;
      result_ready_i = n >= 4 + v.hold;
      start_i        = (n >= 4 && n < 4 + v.hold) ? n[0] : 1'b0;
      chk("apply", 32'(apply_bkt_o), 32'(!v.unsat && n == 3));
      chk("busy", 32'(busy_o), 32'(n <= 4 + v.hold));
      chk("valid", 32'(result_valid_o), 32'(n >= 4 && n <= 4 + v.hold));
      if (n <= 4 + v.hold) chk("max_lvl_o", 32'(max_lvl_o), 32'(v.maxl));
      if (n >= 4 && n <= 4 + v.hold && sb.size() > 0) begin
        e = sb[0];
        chk("bkt_lvl", 32'(bkt_lvl_o), 32'(e.lvl));
        chk("bkt_bin", 32'(bkt_bin_o), 32'(e.bin));
        chk("unsat", 32'(unsat_o), 32'(e.unsat));
        if (n == 4 + v.hold) void'(sb.pop_front());
      end
      if (n == 5 + v.hold) chk("multi_hit", 32'(multi_hit_o), 32'(v.multi));
    end
  endtask

  initial begin
    tbl[0] = '{32'h0000_0020, 16'd7,  5,  10'd77,   1'b0, 1'b0, 0};
    tbl[1] = '{32'h0000_0000, 16'd3,  0,  10'd0,    1'b1, 1'b0, 0};
    tbl[2] = '{32'h0000_0108, 16'd9,  8,  10'd300,  1'b0, 1'b1, 0};
    tbl[3] = '{32'h0000_0040, 16'd6,  6,  10'd555,  1'b0, 1'b1, 10};
    tbl[4] = '{32'h8000_0000, 16'd40, 31, 10'd1023, 1'b0, 1'b1, 0};
    tbl[5] = '{32'h0000_0001, 16'd0,  0,  10'd512,  1'b0, 1'b1, 2};
    tbl[6] = '{32'hFFFF_FFFF, 16'd31, 31, 10'd1,    1'b0, 1'b1, 0};
    tbl[7] = '{32'h0001_0000, 16'd16, 16, 10'd123,  1'b0, 1'b1, 1};

    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_valid", 32'(result_valid_o), 32'd0);
    chk("rst_max_lvl", 32'(max_lvl_o), 32'd0);
    chk("rst_bkt_lvl", 32'(bkt_lvl_o), 32'd0);
    chk("rst_bkt_bin", 32'(bkt_bin_o), 32'd0);
    chk("rst_flags", {29'd0, unsat_o, multi_hit_o, apply_bkt_o}, 32'd0);
    chk("findflag", 32'(findflag_o), 32'd0);
    @(negedge clk);

    for (int k = 0; k < 8; k++) run(tbl[k]);

    // Reset asserted during ENCODE aborts with no apply pulse and clears everything
    findindex_i = 32'h0000_0004;
    max_lvl_i   = 16'd12;
    start_i     = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", 32'(busy_o), 32'd0);
    chk("abort_max_lvl", 32'(max_lvl_o), 32'd0);
    chk("abort_bkt_lvl", 32'(bkt_lvl_o), 32'd0);
    chk("abort_bkt_bin", 32'(bkt_bin_o), 32'd0);
    chk("abort_flags", {29'd0, unsat_o, multi_hit_o, apply_bkt_o}, 32'd0);
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      chk("abort_no_apply", 32'(apply_bkt_o), 32'd0);
      chk("abort_no_valid", 32'(result_valid_o), 32'd0);
    end

    // A fresh search after the abort works and multi_hit starts clear again
    run('{32'h0000_0004, 16'd12, 2, 10'd444, 1'b0, 1'b0, 0});
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end
endmodule
